// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the memory's instruction word with PC+4
// into a one-entry valid/ready output register, and handles stall, redirect, halt and fault.
module fetch_unit #(
  parameter int unsigned MEM_BYTES = 36,
  parameter int unsigned PC_RESET  = 0
) (
  input  logic        clk,
  input  logic        Reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction_code,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] LastPc  = 32'(MEM_BYTES - 4);
  localparam logic [31:0] ResetPc = 32'(PC_RESET);

  typedef enum logic [1:0] {StBoot, StFetch, StHalt, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic transfer, fire, redir_en, target_legal;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= StBoot;
      pc_q    <= ResetPc;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;

    transfer     = valid_q && out_ready;
    redir_en     = redirect_valid && ((state_q == StFetch) || (state_q == StHalt));
    target_legal = (redirect_target[1:0] == 2'b00) && (redirect_target <= LastPc);
    fire         = (state_q == StFetch) && !stall && !redirect_valid && (!valid_q || out_ready);

    if (state_q == StBoot) begin
      state_d = StFetch;
    end

    if (redir_en) begin
      // Redirect always flushes the held (wrong-path) instruction.
      valid_d = 1'b0;
      if (target_legal) begin
        pc_d    = redirect_target;
        state_d = StFetch;
      end else begin
        state_d = StFault;
      end
    end else if (fire) begin
      instr_d = Instruction_code;
      pc4_d   = pc_q + 32'd4;
      valid_d = 1'b1;
      if (pc_q == LastPc) begin
        state_d = StHalt;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  assign PC        = pc_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc4   = pc4_q;
  assign halted    = (state_q == StHalt);
  assign fault     = (state_q == StFault);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 9-word instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        Reset;
  logic [31:0] PC;
  logic [31:0] Instruction_code;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic        halted;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(
    .MEM_BYTES(36),
    .PC_RESET (0)
  ) u_dut (
    .clk             (clk),
    .Reset           (Reset),
    .PC              (PC),
    .Instruction_code(Instruction_code),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc4         (out_pc4),
    .halted          (halted),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word i of memory is C0DE_000i; out-of-range reads return a poison value.
  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  assign Instruction_code = (PC <= 32'd32) ? (32'hC0DE_0000 + (PC >> 2)) : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();
  endtask

  initial begin
    Reset           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    out_ready       = 1'b1;

    // Reset state
    step();
    step();
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_instr", out_instr, 32'h0);
    check_eq("rst_pc4", out_pc4, 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    check_eq("rst_fault", 32'(fault), 32'h0);

    // BOOT cycle: no fetch
    Reset = 1'b1;
    step();
    check_eq("boot_valid", 32'(out_valid), 32'h0);
    check_eq("boot_pc", PC, 32'h0);

    // Streaming W0..W8 with out_ready held high
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq($sformatf("seq_instr%0d", i), out_instr, word(i));
      check_eq($sformatf("seq_pc4_%0d", i), out_pc4, 32'(4 * (i + 1)));
      check_eq($sformatf("seq_valid%0d", i), 32'(out_valid), 32'h1);
    end
    check_eq("halt_flag", 32'(halted), 32'h1);
    check_eq("halt_pc", PC, 32'd32);
    step();
    check_eq("drain_valid", 32'(out_valid), 32'h0);
    check_eq("drain_pc", PC, 32'd32);
    check_eq("drain_halted", 32'(halted), 32'h1);
    step();
    check_eq("halt_idle_valid", 32'(out_valid), 32'h0);

    // Redirect from HALT
    redirect_valid  = 1'b1;
    redirect_target = 32'h14;
    step();
    redirect_valid = 1'b0;
    check_eq("hredir_pc", PC, 32'h14);
    check_eq("hredir_halted", 32'(halted), 32'h0);
    check_eq("hredir_valid", 32'(out_valid), 32'h0);
    step();
    check_eq("hredir_instr", out_instr, word(5));
    check_eq("hredir_pc4", out_pc4, 32'h18);

    // Backpressure holds W1 stable
    do_reset();
    step();
    step();
    check_eq("bp_pre_instr", out_instr, word(1));
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("bp_instr%0d", i), out_instr, word(1));
      check_eq($sformatf("bp_pc4_%0d", i), out_pc4, 32'd8);
      check_eq($sformatf("bp_pc%0d", i), PC, 32'd8);
      check_eq($sformatf("bp_valid%0d", i), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_resume_instr", out_instr, word(2));
    check_eq("bp_resume_pc4", out_pc4, 32'd12);

    // Stall: held W2 drains, no new fetch
    stall = 1'b1;
    step();
    check_eq("stall_valid0", 32'(out_valid), 32'h0);
    check_eq("stall_pc0", PC, 32'd12);
    step();
    check_eq("stall_valid1", 32'(out_valid), 32'h0);
    check_eq("stall_pc1", PC, 32'd12);
    stall = 1'b0;
    step();
    check_eq("stall_resume_instr", out_instr, word(3));
    check_eq("stall_resume_valid", 32'(out_valid), 32'h1);

    // Redirect mid-stream flushes W3
    redirect_valid  = 1'b1;
    redirect_target = 32'h14;
    step();
    redirect_valid = 1'b0;
    check_eq("redir_valid", 32'(out_valid), 32'h0);
    check_eq("redir_pc", PC, 32'h14);
    step();
    check_eq("redir_instr", out_instr, word(5));
    check_eq("redir_pc4", out_pc4, 32'h18);

    // Misaligned target faults; later legal redirect is ignored
    redirect_valid  = 1'b1;
    redirect_target = 32'h06;
    step();
    check_eq("mis_fault", 32'(fault), 32'h1);
    check_eq("mis_valid", 32'(out_valid), 32'h0);
    check_eq("mis_pc", PC, 32'h18);
    redirect_target = 32'h00;
    step();
    redirect_valid = 1'b0;
    check_eq("fault_sticky", 32'(fault), 32'h1);
    check_eq("fault_pc_hold", PC, 32'h18);
    do_reset();
    check_eq("fault_cleared", 32'(fault), 32'h0);

    // Out-of-range target 0x24 faults
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h24;
    step();
    redirect_valid = 1'b0;
    check_eq("oor_fault", 32'(fault), 32'h1);
    check_eq("oor_valid", 32'(out_valid), 32'h0);
    check_eq("oor_pc", PC, 32'h4);

    // Reset glitch between edges has no effect; then a real mid-stream reset
    do_reset();
    step();
    step();
    check_eq("mid_pre_instr", out_instr, word(1));
    #2 Reset = 1'b0;
    #2 Reset = 1'b1;
    step();
    check_eq("glitch_instr", out_instr, word(2));
    check_eq("glitch_pc", PC, 32'd12);
    Reset = 1'b0;
    #2;
    check_eq("sync_valid", 32'(out_valid), 32'h1);
    check_eq("sync_pc", PC, 32'd12);
    step();
    check_eq("mid_rst_pc", PC, 32'h0);
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_instr", out_instr, 32'h0);
    check_eq("mid_rst_pc4", out_pc4, 32'h0);
    Reset = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
